keep_one_in_n_chdr: RTL

Packet-aware sample decimator placed between the RFNoC AXI wrapper's user-side output (m_axis_data, 32-bit samples + 128-bit CHDR tuser) and its user-side input (s_axis_data). It keeps the first sample of every group of N and drops the rest. Each input packet with at least one kept sample produces exactly one output packet, so header reuse in the wrapper's SIMPLE_MODE stays 1:1. The wrapper must run with RESIZE_OUTPUT_PACKET=0; the framer derives the length from o_tlast.

---
 rtl/keep_one_in_n_chdr_pkg.sv | 16 +
 rtl/keep_one_in_n_chdr_axi_hold_reg.sv | 50 +++++
 rtl/keep_one_in_n_chdr.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/keep_one_in_n_chdr_pkg.sv
// Shared CHDR tuser field positions and small helpers for the keep-one-in-N decimator.
package keep_one_in_n_chdr_pkg;

  localparam int USER_W       = 128;
  localparam int N_W          = 16;
  localparam int EOB_BIT      = 124;
  localparam int HAS_TIME_BIT = 125;
  localparam int LEN_HI       = 111;
  localparam int LEN_LO       = 96;

  // A decimation factor of zero would make the phase wrap meaningless, so it means 1.
  function automatic logic [N_W-1:0] sanitize_n(input logic [N_W-1:0] n);
    return (n == '0) ? N_W'(1) : n;
  endfunction

endpackage

// File: rtl/keep_one_in_n_chdr_axi_hold_reg.sv
// One-entry sample hold register with an end-of-packet flag that can be set after loading.
module axi_hold_reg #(
  parameter int WIDTH  = 32,
  parameter int USER_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              take,
  input  logic              set_last,
  input  logic [WIDTH-1:0]  load_data,
  input  logic [USER_W-1:0] load_user,
  input  logic              load_last,
  output logic              valid,
  output logic              last,
  output logic [WIDTH-1:0]  data,
  output logic [USER_W-1:0] user
);

  logic              valid_reg;
  logic              last_reg;
  logic [WIDTH-1:0]  data_reg;
  logic [USER_W-1:0] user_reg;

  // A load replaces the entry even if it is being taken in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      data_reg  <= '0;
      user_reg  <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      last_reg  <= load_last;
      data_reg  <= load_data;
      user_reg  <= load_user;
    end else if (take) begin
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
    end else if (set_last) begin
      last_reg  <= 1'b1;
    end
  end

  assign valid = valid_reg;
  assign last  = last_reg;
  assign data  = data_reg;
  assign user  = user_reg;

endmodule

// File: rtl/keep_one_in_n_chdr.sv
// Packet-aware keep-one-in-N decimator for CHDR sample streams; one output packet per
// input packet that keeps at least one sample, EOB always forwarded.
module keep_one_in_n_chdr
  import keep_one_in_n_chdr_pkg::*;
#(
  parameter int SR_N      = 0,
  parameter int WIDTH     = 32,
  parameter int DEFAULT_N = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              set_stb,
  input  logic [7:0]        set_addr,
  input  logic [31:0]       set_data,
  input  logic [WIDTH-1:0]  i_tdata,
  input  logic [USER_W-1:0] i_tuser,
  input  logic              i_tlast,
  input  logic              i_tvalid,
  output logic              i_tready,
  output logic [WIDTH-1:0]  o_tdata,
  output logic [USER_W-1:0] o_tuser,
  output logic              o_tlast,
  output logic              o_tvalid,
  input  logic              o_tready
);

  localparam logic [N_W-1:0] DEFAULT_N16 = sanitize_n(N_W'(DEFAULT_N));
  localparam logic [7:0]     SR_ADDR     = 8'(SR_N);

  logic              srst;
  logic [N_W-1:0]    n_reg;
  logic [N_W-1:0]    n_pending_reg;
  logic              pending_valid_reg;
  logic [N_W-1:0]    phase_reg;
  logic              in_pkt_reg;
  logic              kept_in_pkt_reg;

  logic              out_valid_reg;
  logic              out_last_reg;
  logic [WIDTH-1:0]  out_data_reg;
  logic [USER_W-1:0] out_user_reg;

  logic              hold_valid;
  logic              hold_last;
  logic [WIDTH-1:0]  hold_data;
  logic [USER_W-1:0] hold_user;

  logic              apply_n;
  logic [N_W-1:0]    n_eff;
  logic [N_W-1:0]    phase_eff;
  logic              kept_eff;
  logic              eob;
  logic              out_free;
  logic              accept;
  logic              kept;
  logic              phase_wrap;
  logic              flush;
  logic              hold_load;
  logic              hold_set_last;
  logic              shift;
  logic              set_n_wr;
  logic              unused_set_bits;

  assign srst = reset | clear;

  // A pending factor takes effect on the first beat of the next packet, so that beat
  // already sees the new N and a zero phase.
  assign apply_n   = pending_valid_reg & ~in_pkt_reg;
  assign n_eff     = apply_n ? n_pending_reg : n_reg;
  assign phase_eff = apply_n ? '0 : phase_reg;
  assign kept_eff  = in_pkt_reg & kept_in_pkt_reg;

  assign eob        = i_tuser[EOB_BIT];
  assign out_free   = ~out_valid_reg | o_tready;
  assign i_tready   = ~(hold_valid & hold_last) & out_free;
  assign accept     = i_tvalid & i_tready;
  assign kept       = (phase_eff == '0) | (i_tlast & eob & ~kept_eff);
  assign phase_wrap = (phase_eff == n_eff - N_W'(1));

  assign flush         = hold_valid & hold_last & out_free;
  assign hold_load     = accept & kept;
  assign hold_set_last = accept & ~kept & i_tlast & hold_valid;
  assign shift         = hold_load & hold_valid;

  assign set_n_wr        = set_stb & (set_addr == SR_ADDR);
  assign unused_set_bits = ^set_data[31:N_W];

  always_ff @(posedge clk) begin
    if (srst) begin
      n_reg             <= DEFAULT_N16;
      n_pending_reg     <= DEFAULT_N16;
      pending_valid_reg <= 1'b0;
      phase_reg         <= '0;
      in_pkt_reg        <= 1'b0;
      kept_in_pkt_reg   <= 1'b0;
    end else begin
      if (apply_n) begin
        n_reg             <= n_pending_reg;
        pending_valid_reg <= 1'b0;
        phase_reg         <= '0;
      end
      if (accept) begin
        if (i_tlast & eob)
          phase_reg <= '0;
        else
          phase_reg <= phase_wrap ? '0 : phase_eff + N_W'(1);
        in_pkt_reg      <= ~i_tlast;
        kept_in_pkt_reg <= ~i_tlast & (kept_eff | kept);
      end
      // A new write always wins over the factor being applied this cycle.
      if (set_n_wr) begin
        n_pending_reg     <= sanitize_n(set_data[N_W-1:0]);
        pending_valid_reg <= 1'b1;
      end
    end
  end

  axi_hold_reg #(
    .WIDTH  (WIDTH),
    .USER_W (USER_W)
  ) u_hold (
    .clk       (clk),
    .reset     (srst),
    .load      (hold_load),
    .take      (flush),
    .set_last  (hold_set_last),
    .load_data (i_tdata),
    .load_user (i_tuser),
    .load_last (i_tlast),
    .valid     (hold_valid),
    .last      (hold_last),
    .data      (hold_data),
    .user      (hold_user)
  );

  // Flush and shift never coincide: a flushable hold blocks the input.
  always_ff @(posedge clk) begin
    if (srst) begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_data_reg  <= '0;
      out_user_reg  <= '0;
    end else if (flush) begin
      out_valid_reg <= 1'b1;
      out_last_reg  <= 1'b1;
      out_data_reg  <= hold_data;
      out_user_reg  <= hold_user;
    end else if (shift) begin
      out_valid_reg <= 1'b1;
      out_last_reg  <= 1'b0;
      out_data_reg  <= hold_data;
      out_user_reg  <= hold_user;
    end else if (o_tready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign o_tvalid = out_valid_reg;
  assign o_tlast  = out_last_reg;
  assign o_tdata  = out_data_reg;
  assign o_tuser  = out_user_reg;

endmodule
